// File: rtl/anti_noise_mixer.sv
// anti_noise_mixer
// Blends the microphone signal with an already-negated, delayed copy of itself
// to cancel steady noise. The anti-noise path is faded in and out by an 8-bit
// ramp gain (0..128, Q1.7). Output gain and saturation are applied afterwards.
//
// Datapath, one register stage each, so audio_valid_out follows audio_valid_in
// by three cycles:
//   stage 1 : anti = (delayed * ramp) >>> 7   (ramp value held before this strobe)
//   stage 2 : sum  = sext(mic) + anti          (17-bit, cannot overflow)
//   stage 3 : y    = (sum * gain) >>> 7, clamped to 16-bit signed
//
// Optional feature: define MIXER_CLIP_COUNT_EN to add clip_count_out, a
// saturating count of output samples that were clamped in stage 3.
module anti_noise_mixer #(
  parameter int RAMP_STEP   = 1,
  parameter int PIPE_STAGES = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               audio_valid_in,
  input  logic signed [15:0] mic_audio_in,
  input  logic signed [15:0] delayed_audio_in,
  input  logic               mix_enable_in,
  input  logic        [7:0]  gain_in,
  output logic signed [15:0] audio_out,
  output logic               audio_valid_out,
  output logic        [1:0]  state_out
`ifdef MIXER_CLIP_COUNT_EN
  ,
  output logic        [15:0] clip_count_out
`endif
);

  // FSM encoding, visible on state_out
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // Ramp full scale is 1.0 in Q1.7
  localparam logic [7:0] RAMP_MAX = 8'd128;
  localparam logic [7:0] STEP_8   = 8'(RAMP_STEP);

  // Scale the delayed sample by the ramp gain: 24-bit signed product, Q1.7 back to integer
  function automatic logic signed [16:0] scale_anti(
    input logic signed [15:0] sample,
    input logic        [7:0]  ramp
  );
    logic signed [23:0] prod;
    prod = $signed({{8{sample[15]}}, sample}) * $signed({16'd0, ramp});
    return 17'(prod >>> 3'd7);
  endfunction

  // Apply the Q1.7 output gain to the 17-bit sum: 26-bit signed result
  function automatic logic signed [25:0] scale_gain(
    input logic signed [16:0] sum,
    input logic        [7:0]  gain
  );
    logic signed [25:0] prod;
    prod = $signed({{9{sum[16]}}, sum}) * $signed({18'd0, gain});
    return prod >>> 3'd7;
  endfunction

  // True when a stage-3 result lies outside the 16-bit signed range
  function automatic logic is_clip(input logic signed [25:0] y);
    return (y > 26'sd32767) || (y < -26'sd32768);
  endfunction

  // Clamp a stage-3 result to the 16-bit signed range
  function automatic logic signed [15:0] sat16(input logic signed [25:0] y);
    logic signed [15:0] r;
    if (y > 26'sd32767) begin
      r = 16'sh7FFF;
    end else if (y < -26'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = y[15:0];
    end
    return r;
  endfunction

  logic        [1:0]             state_r;
  logic        [1:0]             state_nxt_s;
  logic        [7:0]             ramp_r;
  logic        [7:0]             ramp_nxt_s;
  logic        [8:0]             ramp_up_s;
  logic        [7:0]             ramp_dn_s;
  logic        [PIPE_STAGES-1:0] vld_r;
  logic signed [15:0]            mic_r;
  logic signed [16:0]            anti_r;
  logic signed [16:0]            sum_r;
  logic signed [25:0]            y_s;
  logic signed [15:0]            audio_r;

  // Candidate ramp values one step up (9 bits to see the overshoot) and one step down
  assign ramp_up_s = {1'b0, ramp_r} + {1'b0, STEP_8};
  assign ramp_dn_s = ramp_r - STEP_8;

  // Stage 3 arithmetic uses gain_in as it stands on the cycle the sample enters
  assign y_s = scale_gain(sum_r, gain_in);

  // Next FSM state and ramp: every accepted sample steps the ramp toward the
  // requested end. Enable high walks up (ACTIVE holds at 128), enable low walks
  // down (IDLE holds at 0). A change of enable mid-ramp therefore reverses
  // direction from the current ramp value on the same strobe.
  always_comb begin
    state_nxt_s = state_r;
    ramp_nxt_s  = ramp_r;
    if (audio_valid_in) begin
      if (mix_enable_in) begin
        if (ramp_up_s >= {1'b0, RAMP_MAX}) begin
          state_nxt_s = ST_ACTIVE;
          ramp_nxt_s  = RAMP_MAX;
        end else begin
          state_nxt_s = ST_RAMP_UP;
          ramp_nxt_s  = ramp_up_s[7:0];
        end
      end else begin
        if (ramp_r <= STEP_8) begin
          state_nxt_s = ST_IDLE;
          ramp_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = ST_RAMP_DOWN;
          ramp_nxt_s  = ramp_dn_s;
        end
      end
    end else begin
      state_nxt_s = state_r;
      ramp_nxt_s  = ramp_r;
    end
  end

  // FSM state and ramp register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
      ramp_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      ramp_r  <= ramp_nxt_s;
    end
  end

  // Valid bits travelling alongside the samples; cleared on reset so nothing in flight emerges
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_r <= {PIPE_STAGES{1'b0}};
    end else begin
      vld_r <= {vld_r[PIPE_STAGES-2:0], audio_valid_in};
    end
  end

  // Stage 1: capture mic sample and the ramp-scaled anti-noise sample
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mic_r  <= 16'sd0;
      anti_r <= 17'sd0;
    end else if (audio_valid_in) begin
      mic_r  <= mic_audio_in;
      anti_r <= scale_anti(delayed_audio_in, ramp_r);
    end
  end

  // Stage 2: mix in 17 bits so the sum never wraps
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sum_r <= 17'sd0;
    end else if (vld_r[0]) begin
      sum_r <= $signed({mic_r[15], mic_r}) + anti_r;
    end
  end

  // Stage 3: gain, clamp and hold the output until the next sample
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      audio_r <= 16'sd0;
    end else if (vld_r[1]) begin
      audio_r <= sat16(y_s);
    end
  end

`ifdef MIXER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_r;

  // Count clamped output samples, sticking at full scale
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clip_cnt_r <= 16'd0;
    end else if (vld_r[1] && is_clip(y_s) && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end
  end

  assign clip_count_out = clip_cnt_r;
`endif

  assign audio_out       = audio_r;
  assign audio_valid_out = vld_r[PIPE_STAGES-1];
  assign state_out       = state_r;

endmodule

// File: tb/tb_anti_noise_mixer.sv
// tb_anti_noise_mixer
// Directed vectors with hand-computed results for anti_noise_mixer
// (RAMP_STEP = 1). Inputs change on the falling clock edge, outputs are
// sampled on the falling edge as well.
module tb_anti_noise_mixer;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               audio_valid_in;
  logic signed [15:0] mic_audio_in;
  logic signed [15:0] delayed_audio_in;
  logic               mix_enable_in;
  logic        [7:0]  gain_in;
  logic signed [15:0] audio_out;
  logic               audio_valid_out;
  logic        [1:0]  state_out;
`ifdef MIXER_CLIP_COUNT_EN
  logic        [15:0] clip_count_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  anti_noise_mixer #(
    .RAMP_STEP  (1),
    .PIPE_STAGES(3)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_valid_in  (audio_valid_in),
    .mic_audio_in    (mic_audio_in),
    .delayed_audio_in(delayed_audio_in),
    .mix_enable_in   (mix_enable_in),
    .gain_in         (gain_in),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .state_out       (state_out)
`ifdef MIXER_CLIP_COUNT_EN
    ,
    .clip_count_out  (clip_count_out)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int mic, input int del, input int g, input logic en);
    mic_audio_in     = 16'(mic);
    delayed_audio_in = 16'(del);
    gain_in          = 8'(g);
    mix_enable_in    = en;
  endtask

  // One isolated sample: checks the 3-cycle latency and the result
  task automatic one_sample(input string tag, input int mic, input int del,
                            input int g, input logic en, input int exp);
    @(negedge clk_in);
    drive(mic, del, g, en);
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    chk({tag, "_lat1"}, int'(audio_valid_out), 0);
    @(negedge clk_in);
    chk({tag, "_lat2"}, int'(audio_valid_out), 0);
    @(negedge clk_in);
    chk({tag, "_vld"}, int'(audio_valid_out), 1);
    chk({tag, "_out"}, int'(audio_out), exp);
  endtask

  // n back-to-back strobes with fixed inputs, then drain the pipeline
  task automatic burst(input int n, input int mic, input int del, input int g, input logic en);
    @(negedge clk_in);
    drive(mic, del, g, en);
    audio_valid_in = 1'b1;
    repeat (n) @(negedge clk_in);
    audio_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in         = 1'b1;
    audio_valid_in = 1'b0;
    drive(0, 0, 128, 1'b0);
    #2 rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_out", int'(audio_out), 0);
    chk("rst_vld", int'(audio_valid_out), 0);
    chk("rst_state", int'(state_out), 0);

    // Release reset and strobe so the very next rising edge takes the sample
    @(negedge clk_in);
    rst_in = 1'b1;
    drive(1000, -500, 128, 1'b0);
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    chk("first_lat1", int'(audio_valid_out), 0);
    @(negedge clk_in);
    chk("first_lat2", int'(audio_valid_out), 0);
    @(negedge clk_in);
    chk("first_vld", int'(audio_valid_out), 1);
    chk("first_out", int'(audio_out), 1000);
    chk("first_state", int'(state_out), 0);
    @(negedge clk_in);
    chk("hold_vld", int'(audio_valid_out), 0);
    chk("hold_out", int'(audio_out), 1000);

    // Gain is taken when the sample enters stage 3, not when it is strobed
    @(negedge clk_in);
    drive(200, 0, 0, 1'b0);
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    @(negedge clk_in);
    gain_in = 8'd128;
    @(negedge clk_in);
    chk("gain_late_out", int'(audio_out), 200);
    gain_in = 8'd255;
    @(negedge clk_in);
    chk("gain_after_out", int'(audio_out), 200);

    // IDLE ignores the delayed path; arithmetic shift floors negatives
    one_sample("neg_a", -1000, 12345, 64, 1'b0, -500);
    one_sample("neg_b", -1001, 12345, 64, 1'b0, -501);

    // Fade in: state ACTIVE exactly after the 128th strobe, which still uses ramp 127
    one_sample("up1", 0, 0, 128, 1'b1, 0);
    chk("up1_state", int'(state_out), 1);
    burst(126, 0, 0, 128, 1'b1);
    chk("up127_state", int'(state_out), 1);
    one_sample("up128", 1000, -500, 128, 1'b1, 503);
    chk("up128_state", int'(state_out), 2);
    one_sample("active", 1000, -500, 128, 1'b1, 500);
    chk("active_state", int'(state_out), 2);

    // Saturation both ways and an unclipped high-gain sample
    one_sample("clip_pos", 30000, 10000, 255, 1'b1, 32767);
`ifdef MIXER_CLIP_COUNT_EN
    chk("clip_cnt", int'(clip_count_out), 1);
`endif
    one_sample("clip_neg", -30000, -10000, 255, 1'b1, -32768);
    one_sample("gain255", 100, 0, 255, 1'b1, 199);

    // Three strobes on consecutive cycles come out on consecutive cycles, in order
    @(negedge clk_in);
    drive(100, 50, 128, 1'b1);
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    drive(-200, -300, 128, 1'b1);
    @(negedge clk_in);
    drive(32767, 32767, 128, 1'b1);
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    chk("b2b0_vld", int'(audio_valid_out), 1);
    chk("b2b0_out", int'(audio_out), 150);
    @(negedge clk_in);
    chk("b2b1_vld", int'(audio_valid_out), 1);
    chk("b2b1_out", int'(audio_out), -500);
    @(negedge clk_in);
    chk("b2b2_vld", int'(audio_valid_out), 1);
    chk("b2b2_out", int'(audio_out), 32767);
    @(negedge clk_in);
    chk("b2b_end_vld", int'(audio_valid_out), 0);

    // Fade out fully: ramp 128 needs 128 strobes to reach IDLE
    burst(127, 0, 0, 128, 1'b0);
    chk("down127_state", int'(state_out), 3);
    burst(1, 0, 0, 128, 1'b0);
    chk("down128_state", int'(state_out), 0);

    // Reversal mid fade-in at ramp 64
    burst(64, 0, 0, 128, 1'b1);
    chk("up64_state", int'(state_out), 1);
    one_sample("rev", 1000, -500, 128, 1'b0, 750);
    chk("rev_state", int'(state_out), 3);
    one_sample("rd63", 1000, -500, 128, 1'b0, 753);
    chk("rd63_state", int'(state_out), 3);
    burst(61, 0, 0, 128, 1'b0);
    chk("rd_last_state", int'(state_out), 3);
    burst(1, 0, 0, 128, 1'b0);
    chk("rd_idle_state", int'(state_out), 0);
    one_sample("idle_again", 1000, -500, 128, 1'b0, 1000);

    // Reset one cycle after a strobe, mid fade-in
    burst(5, 0, 0, 128, 1'b1);
    one_sample("pre_rst", 1000, 0, 128, 1'b1, 1000);
    @(negedge clk_in);
    drive(2000, 0, 128, 1'b1);
    audio_valid_in = 1'b1;
    @(negedge clk_in);
    audio_valid_in = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_out", int'(audio_out), 0);
    chk("mid_rst_vld", int'(audio_valid_out), 0);
    chk("mid_rst_state", int'(state_out), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk($sformatf("mid_rst_drop%0d", i), int'(audio_valid_out), 0);
    end
    one_sample("post_rst", 1000, -500, 128, 1'b0, 1000);
    chk("post_rst_state", int'(state_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
